// File: rtl/store_buffer_if.sv
// Pipeline/memory-side signal bundle for the store buffer.
// The slave modport is the buffer; the master modport is the pipeline + data memory side.
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, fwd_hit, fwd_data, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, fwd_hit, fwd_data, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/store_buffer.sv
// In-order write-back store buffer: drains to the data memory port when no load
// needs it, and forwards the youngest matching buffered store to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  store_buffer_if.slave          bus,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [PW-1:0] idx;

  // Reset forces the buffer to look empty so a drain in progress stops at once.
  always_comb begin
    empty        = !rst || (count_q == '0);
    full         = rst && (count_q == CW'(DEPTH));
    count        = count_q;
    bus.st_ready = rst && !full;
  end

  // NOTE: every output gets a default before the if/else chain, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (bus.ld_valid) begin
      bus.mem_read = 1'b1;
      bus.mem_addr = bus.ld_addr;
    end else if (!empty) begin
      bus.mem_write = 1'b1;
      bus.mem_addr  = addr_q[head_q];
      bus.mem_wdata = data_q[head_q];
    end
  end

  // Scan oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    idx          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (bus.ld_valid && rst && (CW'(i) < count_q) && (addr_q[idx] == bus.ld_addr)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = data_q[idx];
      end
    end
  end

  always_comb begin
    push    = bus.st_valid && bus.st_ready;
    pop     = bus.mem_write;
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge; combinational blocks above use blocking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage has no reset; count_q alone decides which entries are
  // live, so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued on accept
// and compared when the buffer drains; forwarding is checked against the queue.
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       empty, full;
  logic [2:0] count;
  int         n_checks = 0;
  int         n_errors = 0;
  wr_t        sb[$];

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: check port use and forwarding, pop on drain, push on accept.
  always @(negedge clk) begin
    wr_t         e;
    logic        exp_hit;
    logic [31:0] exp_data;
    if (!rst) begin
      check("rst_mem_write", bus.mem_write, 1'b0);
      sb.delete();
    end else begin
      check("drain_active", bus.mem_write, !bus.ld_valid && (sb.size() != 0));
      if (bus.ld_valid) begin
        check("ld_port", {bus.mem_read, bus.mem_write, bus.mem_addr},
              {1'b1, 1'b0, bus.ld_addr});
        exp_hit  = 1'b0;
        exp_data = '0;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].addr == bus.ld_addr) begin
            exp_hit  = 1'b1;
            exp_data = sb[i].data;
          end
        end
        check("fwd_hit", bus.fwd_hit, exp_hit);
        check("fwd_data", bus.fwd_data, exp_data);
      end
      if (bus.mem_write) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_data", bus.mem_wdata, e.data);
        end
      end
      if (bus.st_valid && bus.st_ready) begin
        e.addr = bus.st_addr;
        e.data = bus.st_data;
        sb.push_back(e);
      end
    end
  end

  initial begin
    // Reset held for two edges with a store presented
    drive(1'b1, 32'h99, 32'h1234_5678, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", count, 3'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_st_ready", bus.st_ready, 1'b0);
    check("rst_mem_write_direct", bus.mem_write, 1'b0);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("post_rst_st_ready", bus.st_ready, 1'b1);
    check("post_rst_empty", empty, 1'b1);
    next_cycle();

    // Single store drains on the following cycle
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, '0);
    @(negedge clk);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("single_write", bus.mem_write, 1'b1);
    check("single_addr", bus.mem_addr, 32'h10);
    check("single_data", bus.mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    check("single_empty", empty, 1'b1);
    next_cycle();

    // Fill behind a load, refuse a fifth store, then drain in order; three
    // passes move head and tail through the wrap.
    for (int iter = 0; iter < 3; iter++) begin
      for (int i = 0; i < DEPTH; i++) begin
        drive(1'b1, 32'(i), 32'hA000 + 32'(iter * 16 + i), 1'b1, 32'h80);
        @(negedge clk);
        next_cycle();
      end
      drive(1'b1, 32'h4, 32'hBAD, 1'b1, 32'h80);
      @(negedge clk);
      check("fill_full", full, 1'b1);
      check("fill_st_ready", bus.st_ready, 1'b0);
      check("fill_count", count, 3'd4);
      next_cycle();
      drive(1'b0, '0, '0, 1'b1, 32'h80);
      @(negedge clk);
      check("refused_count", count, 3'd4);
      next_cycle();
      drive(1'b0, '0, '0, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) begin
        @(negedge clk);
        check("drain_order", bus.mem_addr, 32'(i));
        next_cycle();
      end
      @(negedge clk);
      check("drain_empty", empty, 1'b1);
      next_cycle();
    end

    // Forwarding: youngest match wins, miss gives zero, same-cycle store is no source
    drive(1'b1, 32'h20, 32'h1111, 1'b1, 32'h80);
    @(negedge clk);
    next_cycle();
    drive(1'b1, 32'h20, 32'h2222, 1'b1, 32'h80);
    @(negedge clk);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1, 32'h20);
    @(negedge clk);
    check("fwd_youngest_hit", bus.fwd_hit, 1'b1);
    check("fwd_youngest_data", bus.fwd_data, 32'h2222);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1, 32'h24);
    @(negedge clk);
    check("fwd_miss_hit", bus.fwd_hit, 1'b0);
    check("fwd_miss_data", bus.fwd_data, 32'h0);
    next_cycle();
    drive(1'b1, 32'h30, 32'h3333, 1'b1, 32'h30);
    @(negedge clk);
    check("fwd_same_cycle", bus.fwd_hit, 1'b0);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1, 32'h30);
    @(negedge clk);
    check("fwd_next_cycle", bus.fwd_data, 32'h3333);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0, '0);
    repeat (3) begin
      @(negedge clk);
      next_cycle();
    end
    @(negedge clk);
    check("fwd_drained", empty, 1'b1);
    next_cycle();

    // Push and pop in the same cycle keep count steady
    drive(1'b1, 32'h40, 32'h4040, 1'b1, 32'h80);
    @(negedge clk);
    next_cycle();
    drive(1'b1, 32'h44, 32'h4444, 1'b1, 32'h80);
    @(negedge clk);
    next_cycle();
    drive(1'b1, 32'h48, 32'h4848, 1'b0, '0);
    @(negedge clk);
    check("pp_count_before", count, 3'd2);
    check("pp_st_ready", bus.st_ready, 1'b1);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("pp_count_after", count, 3'd2);
    next_cycle();
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    check("pp_empty", empty, 1'b1);
    next_cycle();

    // Reset mid-drain discards the remaining entries
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h50 + 32'(4 * i), 32'h5000 + 32'(i), 1'b1, 32'h80);
      @(negedge clk);
      next_cycle();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    check("mid_drain_write", bus.mem_write, 1'b1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_count", count, 3'd0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_write", bus.mem_write, 1'b0);
    next_cycle();
    repeat (3) begin
      @(negedge clk);
      next_cycle();
    end

    // Random mix of stores and loads; the scoreboard checks every write and forward
    for (int c = 0; c < 200; c++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2, $urandom,
            ($urandom_range(0, 2) == 0), 32'($urandom_range(0, 7)) << 2);
      @(negedge clk);
      next_cycle();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    repeat (DEPTH + 2) begin
      @(negedge clk);
      next_cycle();
    end
    @(negedge clk);
    check("final_empty", empty, 1'b1);
    check("sb_left", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Write-back store buffer between the MEM pipeline stage and the data memory. It accepts word stores from the pipeline, holds them in a small in-order FIFO, and retires them to the data memory port in cycles when no load needs that port. Loads in the MEM stage get the memory port with priority. A load whose address matches a buffered store receives that store's data by forwarding, so the pipeline never reads stale memory.

## Interface

**Parameters**
- DEPTH, 4: number of buffered stores; power of two, minimum 2.
- AW, 32: address width.
- DW, 32: data width.

**Ports**
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_addr  in  AW  store word address.
- st_data  in  DW  store data.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  MEM stage presents a load this cycle.
- ld_addr  in  AW  load word address.
- fwd_hit  out  1  ld_addr matches a buffered store.
- fwd_data  out  DW  data of the youngest matching buffered store.
- mem_read  out  1  to data memory MemRead.
- mem_write  out  1  to data memory MemWrite.
- mem_addr  out  AW  to data memory Address.
- mem_wdata  out  DW  to data memory WriteVal.
- empty  out  1  no stores pending.
- full  out  1  DEPTH stores pending.
- count  out  clog2(DEPTH)+1  number of pending stores.

## Operation

**Storage and pointers**
- Circular FIFO of {addr, data} entries with head (oldest) and tail pointers of clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- count is a separate register ranging 0..DEPTH.

**Push**
- Occurs when st_valid && st_ready at posedge.
- Writes {st_addr, st_data} at tail; tail increments.
- st_ready = rst && !full. A store is refused while full, even in a cycle where a drain pops an entry.

**Port arbitration (combinational, this cycle)**
- If ld_valid: mem_read=1, mem_write=0, mem_addr=ld_addr, mem_wdata=0.
- Else if !empty: mem_read=0, mem_write=1, mem_addr=head.addr, mem_wdata=head.data.
- Else all memory outputs are 0.

**Pop**
- Occurs at the posedge where mem_write=1; the memory commits the write on the same edge.
- head increments.

**Count**
- Push only: +1. Pop only: -1. Push and pop together: unchanged.
- Derived flags: empty = (count==0), full = (count==DEPTH).

**Forwarding (combinational)**
- fwd_hit = ld_valid && some valid entry has addr==ld_addr.
- fwd_data = data of the youngest such entry (closest to tail); 0 when there is no hit.
- A store being pushed in the same cycle is not a forwarding source.
- The downstream load mux selects fwd_data over memory Out when fwd_hit is set. Because the memory port still performs the read, fwd_hit must be registered alongside the memory's negedge Out.

**Loads and stores together**
- ld_valid && st_valid together is not produced by the single-issue pipeline.
- If it does occur, the load takes the port and the store is still pushed if st_ready.

**Reset**
- On a posedge with rst=0: head=tail=count=0, and all pending stores are discarded, including a drain in progress.
- During reset: st_ready=0, empty=1, full=0.
- Entry contents need not be cleared.

## Timing

- A store accepted at edge N is visible to forwarding from cycle N+1. Its earliest memory write is at edge N+1, if no load occurs in cycle N+1.
- A load is never delayed by the buffer; forwarding has zero cycles of latency.
- Drain throughput: one store per cycle without loads. A continuous stream of loads stalls draining indefinitely; the pipeline must stall on !st_ready.
- Head and tail wrap from DEPTH-1 to 0 with no lost entries. The full/empty distinction comes from count alone.
- All outputs are valid from the first cycle after rst returns high.

## Test plan

- **Reset:** hold rst=0 for 2 cycles with st_valid=1 → count=0, empty=1, st_ready=0, mem_write=0; after release, st_ready=1.
- **Single store:** store addr=0x10, data=0xDEADBEEF with no loads → next cycle mem_write=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; the following cycle empty=1.
- **Fill and wrap:**
  - Hold ld_valid=1 (addr=0x80) while pushing 4 stores (addr 0..3) → full=1, st_ready=0; a 5th st_valid is refused.
  - Drop ld_valid → writes to addr 0,1,2,3 in order, one per cycle.
  - Repeat the fill twice to exercise pointer wrap.
- **Forwarding, youngest wins:**
  - With loads blocking drain, store 0x20←0x1111, then 0x20←0x2222, then load 0x20 → fwd_hit=1, fwd_data=0x2222.
  - Load 0x24 → fwd_hit=0, fwd_data=0.
- **Push and pop together:** count=2, no load, new store accepted → count stays 2; memory write order matches push order.
- **Reset mid-drain:** 3 stores pending, assert rst=0 for one edge → no further mem_write, count=0, empty=1.
